// File: rtl/minifloat_pkg.sv
// Shared definitions for the minifloat converter arbiter.
//   MANT_W/EXP_W : minifloat field widths (two's complement)
//   FRAC_W/FIX_W : fixed-point fraction bits and total result width
//   CNT_W        : accepted-request counter width
//   out_state_e  : result register occupancy
package minifloat_pkg;

  localparam int unsigned MANT_W = 4;
  localparam int unsigned EXP_W  = 3;
  localparam int unsigned FRAC_W = 4;
  localparam int unsigned FIX_W  = 11;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/minifloat_to_fixed.sv
// Combinational minifloat to fixed-point converter: fix = mant * 2^exp * 2^FRAC_W.
//   mant : 4-bit two's complement mantissa
//   exp  : 3-bit two's complement exponent (-4..+3)
//   fix  : 11-bit two's complement result, 4 fractional bits
module minifloat_to_fixed
  import minifloat_pkg::*;
(
  input  logic [MANT_W-1:0] mant,
  input  logic [EXP_W-1:0]  exp,
  output logic [FIX_W-1:0]  fix
);

  logic signed [FIX_W-1:0] base;
  logic [EXP_W-1:0]        rshift;

  // Every mant/exp pair fits in FIX_W bits, so no saturation is needed.
  always_comb begin
    base   = {{(FIX_W - MANT_W - FRAC_W){mant[MANT_W-1]}}, mant, {FRAC_W{1'b0}}};
    rshift = EXP_W'(~exp + EXP_W'(1));
    if (exp[EXP_W-1]) begin
      fix = FIX_W'(base >>> rshift);
    end else begin
      fix = FIX_W'(base << exp[EXP_W-2:0]);
    end
  end

endmodule

// File: rtl/minifloat_conv_arbiter.sv
// Round-robin arbiter sharing one minifloat converter between NREQ requesters,
// with a one-entry registered result and backpressure.
//   clk, reset            : clock, synchronous active-high reset
//   req_valid/req_ready   : per-requester handshake (req_ready one-hot grant)
//   req_mant/req_exp      : packed per-requester minifloat operands
//   out_valid/out_ready   : result handshake
//   out_data/out_id       : converted value and the requester that produced it
//   conv_count            : accepted-request count, wraps
module minifloat_conv_arbiter
  import minifloat_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [MANT_W*NREQ-1:0]   req_mant,
  input  logic [EXP_W*NREQ-1:0]    req_exp,
  output logic [NREQ-1:0]          req_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [FIX_W-1:0]         out_data,
  output logic [IDW-1:0]           out_id,
  output logic [CNT_W-1:0]         conv_count
);

  out_state_e        state_q, state_d;
  logic [IDW-1:0]    last_id;
  logic [IDW-1:0]    grant_id;
  logic [IDW-1:0]    idx;
  logic              grant_found;
  logic              allowed;
  logic              accept;
  logic [MANT_W-1:0] sel_mant;
  logic [EXP_W-1:0]  sel_exp;
  logic [FIX_W-1:0]  conv_fix;

  assign out_valid = (state_q == ST_FULL);

  // Grant opportunity: result slot free now or being drained this cycle.
  assign allowed = !reset && ((state_q == ST_EMPTY) || out_ready);

  // Round-robin search starting just after the last accepted requester.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    idx         = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = IDW'((32'(last_id) + k) % NREQ);
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_id    = idx;
      end
    end
  end

  assign accept = allowed && grant_found;

  // One-hot ready plus operand mux; operands never feed back into the grant.
  always_comb begin
    req_ready = '0;
    sel_mant  = '0;
    sel_exp   = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (grant_id == IDW'(i)) begin
        req_ready[i] = accept;
        sel_mant     = req_mant[MANT_W*i +: MANT_W];
        sel_exp      = req_exp[EXP_W*i +: EXP_W];
      end
    end
  end

  minifloat_to_fixed u_conv (
    .mant (sel_mant),
    .exp  (sel_exp),
    .fix  (conv_fix)
  );

  // Result register occupancy.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL:  if (!accept && out_ready) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      out_data   <= '0;
      out_id     <= '0;
      conv_count <= '0;
      last_id    <= IDW'(NREQ - 1);
    end else begin
      state_q <= state_d;
      if (accept) begin
        out_data   <= conv_fix;
        out_id     <= grant_id;
        last_id    <= grant_id;
        conv_count <= conv_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_minifloat_conv_arbiter.sv
// Self-checking bench for minifloat_conv_arbiter against a behavioural model.
module tb_minifloat_conv_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                clk = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req_valid;
  logic [4*NREQ-1:0]   req_mant;
  logic [3*NREQ-1:0]   req_exp;
  logic [NREQ-1:0]     req_ready;
  logic                out_valid;
  logic                out_ready;
  logic [10:0]         out_data;
  logic [IDW-1:0]      out_id;
  logic [15:0]         conv_count;

  int vectors = 0;
  int errors  = 0;

  // Behavioural model state
  int          m_last;
  bit          m_full;
  logic [10:0] m_data;
  int          m_id;
  int          m_count;

  minifloat_conv_arbiter #(.NREQ(NREQ)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_mant   (req_mant),
    .req_exp    (req_exp),
    .req_ready  (req_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_id     (out_id),
    .conv_count (conv_count)
  );

  always #5 clk = ~clk;

  // value = mant * 2^exp * 16, computed with integer arithmetic
  function automatic logic [10:0] ref_conv(input logic [3:0] mant, input logic [2:0] e);
    int m, x, v;
    m = int'($signed(mant));
    x = int'($signed(e));
    v = m * 16;
    if (x >= 0) v = v * (1 << x);
    else        v = v / (1 << (-x));
    return 11'(v);
  endfunction

  function automatic int model_grant();
    int idx;
    if (reset) return -1;
    if (m_full && !out_ready) return -1;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (m_last + k) % NREQ;
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] model_ready();
    int g;
    logic [NREQ-1:0] r;
    g = model_grant();
    r = '0;
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic model_edge();
    int g;
    g = model_grant();
    if (reset) begin
      m_full = 0; m_data = '0; m_id = 0; m_count = 0; m_last = NREQ - 1;
    end else if (g >= 0) begin
      m_data  = ref_conv(req_mant[4*g +: 4], req_exp[3*g +: 3]);
      m_id    = g;
      m_last  = g;
      m_full  = 1;
      m_count = (m_count + 1) % 65536;
    end else if (out_ready) begin
      m_full = 0;
    end
  endtask

  // Advance one clock: update model with pre-edge inputs, then settle after edge.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = '0;
    req_mant  = '0;
    req_exp   = '0;
    out_ready = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    req_valid = '1;
    #1;
    vectors++;
    if (req_ready !== '0) begin
      errors++; $display("FAIL reset_ready: got %b want 0", req_ready);
    end
    step();
    step();
    vectors++;
    if (out_valid !== 1'b0 || out_data !== 11'h0 || out_id !== '0 || conv_count !== 16'h0) begin
      errors++;
      $display("FAIL reset_state: valid=%b data=%h id=%0d cnt=%0d want 0/0/0/0",
               out_valid, out_data, out_id, conv_count);
    end
    reset = 1'b0;
    req_valid = '0;
    #1;
  endtask

  task automatic test_single();
    do_reset();
    req_valid[0]   = 1'b1;
    req_mant[3:0]  = 4'b0101;
    req_exp[2:0]   = 3'b010;
    #1;
    vectors++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL single_ready: got %b want 0001", req_ready);
    end
    step();
    req_valid = '0;
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 11'h140 || out_id !== 2'd0 || conv_count !== 16'd1) begin
      errors++;
      $display("FAIL single_result: valid=%b data=%h id=%0d cnt=%0d want 1/140/0/1",
               out_valid, out_data, out_id, conv_count);
    end
  endtask

  task automatic test_extremes();
    logic [3:0]  mants [3];
    logic [2:0]  exps  [3];
    logic [10:0] wants [3];
    mants = '{4'b0111, 4'b1000, 4'b1111};
    exps  = '{3'b011, 3'b100, 3'b111};
    wants = '{11'h380, 11'h7F8, 11'h7F8};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      req_valid     = 4'b0001;
      req_mant[3:0] = mants[i];
      req_exp[2:0]  = exps[i];
      step();
      vectors++;
      if (out_valid !== 1'b1 || out_data !== wants[i]) begin
        errors++;
        $display("FAIL extreme_%0d: valid=%b data=%h want 1/%h", i, out_valid, out_data, wants[i]);
      end
    end
    req_valid = '0;
    step();
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] want;
    do_reset();
    req_valid = '1;
    req_mant  = 16'($urandom);
    req_exp   = 12'($urandom);
    for (int k = 0; k < 8; k++) begin
      #1;
      want = '0;
      want[k % NREQ] = 1'b1;
      vectors++;
      if (req_ready !== want) begin
        errors++; $display("FAIL rr_grant_%0d: got %b want %b", k, req_ready, want);
      end
      step();
      vectors++;
      if (out_valid !== 1'b1 || int'(out_id) != (k % NREQ) || out_data !== m_data) begin
        errors++;
        $display("FAIL rr_out_%0d: valid=%b id=%0d data=%h want 1/%0d/%h",
                 k, out_valid, out_id, out_data, k % NREQ, m_data);
      end
      req_mant = 16'($urandom);
      req_exp  = 12'($urandom);
    end
    req_valid = '0;
  endtask

  task automatic test_back_to_back_stall();
    logic [10:0] held_data;
    logic [IDW-1:0] held_id;
    logic [NREQ-1:0] want;
    do_reset();
    req_valid = '1;
    req_mant  = 16'($urandom);
    req_exp   = 12'($urandom);
    step();
    held_data = m_data;
    held_id   = IDW'(m_id);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req_mant = 16'($urandom);
      #1;
      vectors++;
      if (req_ready !== '0) begin
        errors++; $display("FAIL stall_ready_%0d: got %b want 0", k, req_ready);
      end
      step();
      vectors++;
      if (out_valid !== 1'b1 || out_data !== held_data || out_id !== held_id) begin
        errors++;
        $display("FAIL stall_hold_%0d: valid=%b data=%h id=%0d want 1/%h/%0d",
                 k, out_valid, out_data, out_id, held_data, held_id);
      end
    end
    out_ready = 1'b1;
    #1;
    want = 4'b0010;
    vectors++;
    if (req_ready !== want) begin
      errors++; $display("FAIL stall_release_ready: got %b want %b", req_ready, want);
    end
    step();
    vectors++;
    if (out_valid !== 1'b1 || out_id !== 2'd1 || out_data !== m_data || conv_count !== 16'd2) begin
      errors++;
      $display("FAIL stall_release_out: valid=%b id=%0d data=%h cnt=%0d want 1/1/%h/2",
               out_valid, out_id, out_data, conv_count, m_data);
    end
    req_valid = '0;
  endtask

  task automatic test_midstream_reset();
    do_reset();
    req_valid = '1;
    req_mant  = 16'($urandom);
    req_exp   = 12'($urandom);
    step();
    step();
    out_ready = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || conv_count !== 16'd0) begin
      errors++;
      $display("FAIL midreset_state: valid=%b cnt=%0d want 0/0", out_valid, conv_count);
    end
    #1;
    vectors++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL midreset_first_grant: got %b want 0001", req_ready);
    end
    step();
    vectors++;
    if (out_valid !== 1'b1 || out_id !== 2'd0 || conv_count !== 16'd1) begin
      errors++;
      $display("FAIL midreset_after: valid=%b id=%0d cnt=%0d want 1/0/1", out_valid, out_id, conv_count);
    end
    req_valid = '0;
    out_ready = 1'b1;
  endtask

  task automatic test_sweep();
    logic [3:0]  mt;
    logic [2:0]  ex;
    logic [10:0] want;
    do_reset();
    for (int i = 0; i < 128; i++) begin
      mt = 4'(i >> 3);
      ex = 3'(i);
      req_valid = 4'b0100;
      req_mant  = 16'($urandom);
      req_exp   = 12'($urandom);
      req_mant[11:8] = mt;
      req_exp[8:6]   = ex;
      want = ref_conv(mt, ex);
      step();
      vectors++;
      if (out_valid !== 1'b1 || out_id !== 2'd2 || out_data !== want) begin
        errors++;
        $display("FAIL sweep m=%b e=%b: valid=%b id=%0d data=%h want 1/2/%h",
                 mt, ex, out_valid, out_id, out_data, want);
      end
    end
    req_valid = '0;
  endtask

  task automatic test_random();
    logic [NREQ-1:0] want;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      req_valid = 4'($urandom);
      req_mant  = 16'($urandom);
      req_exp   = 12'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      want = model_ready();
      vectors++;
      if (req_ready !== want) begin
        errors++; $display("FAIL rand_ready_%0d: got %b want %b", i, req_ready, want);
      end
      step();
      vectors++;
      if (out_valid !== m_full || int'(conv_count) != m_count ||
          (m_full && (out_data !== m_data || int'(out_id) != m_id))) begin
        errors++;
        $display("FAIL rand_out_%0d: valid=%b data=%h id=%0d cnt=%0d want %b/%h/%0d/%0d",
                 i, out_valid, out_data, out_id, conv_count, m_full, m_data, m_id, m_count);
      end
    end
    idle_inputs();
  endtask

  task automatic test_counter_wrap();
    do_reset();
    req_valid = 4'b0001;
    for (int i = 0; i < 65536; i++) step();
    vectors++;
    if (conv_count !== 16'd0) begin
      errors++; $display("FAIL count_rollover: got %0d want 0", conv_count);
    end
    step();
    vectors++;
    if (conv_count !== 16'd1) begin
      errors++; $display("FAIL count_65537: got %0d want 1", conv_count);
    end
    req_valid = '0;
  endtask

  initial begin
    m_last = NREQ - 1; m_full = 0; m_data = '0; m_id = 0; m_count = 0;
    test_reset();
    test_single();
    test_extremes();
    test_round_robin();
    test_back_to_back_stall();
    test_midstream_reset();
    test_sweep();
    test_random();
    test_counter_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
